// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the divider sequencing controller.
// Op encoding, controller states and result-select function.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } div_state_t;

    localparam int DIV_LATENCY = 67;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    function automatic logic is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

    // c is {rem, quot}; W forms sign-extend the low word.
    function automatic logic [63:0] sel_result(
        input logic [127:0] c,
        input logic         rem,
        input logic         w
    );
        logic [63:0] v;
        v = rem ? c[127:64] : c[63:0];
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

endpackage

// File: rtl/div.sv
// Iterative 64-bit restoring divider, one quotient bit per cycle.
// done rises DIV_LATENCY edges after valid first rises; c is {rem, quot}.
module div
    import div_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         valid,
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    input  logic         s,
    input  logic         w,
    output logic         done,
    output logic [127:0] c
);

    logic [63:0] ea;
    logic [63:0] eb;
    logic        na;
    logic        nb;
    logic [63:0] ma;
    logic [63:0] mb;
    logic        run;
    logic [6:0]  cnt;
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] d;
    logic [64:0] t;
    logic        ge;
    logic [63:0] diff;

    assign ea = w ? (s ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]}) : a;
    assign eb = w ? (s ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]}) : b;
    assign na = s & ea[63];
    assign nb = s & eb[63];
    assign ma = na ? (~ea + 64'd1) : ea;
    assign mb = nb ? (~eb + 64'd1) : eb;

    assign t    = {r, q[63]};
    assign ge   = t >= {1'b0, d};
    assign diff = t[63:0] - d;

    // Sign correction is combinational on the held operands.
    assign c = {na ? (~r + 64'd1) : r,
                (na ^ nb) ? (~q + 64'd1) : q};

    // Load magnitudes, shift-subtract 64 times, then flag done.
    always_ff @(posedge clk) begin
        if (reset || !valid) begin
            run  <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else if (!run) begin
            run <= 1'b1;
            cnt <= '0;
            q   <= ma;
            r   <= '0;
            d   <= mb;
        end else if (!done) begin
            if (cnt < 7'd64) begin
                q <= {q[62:0], ge};
                r <= ge ? diff : t[63:0];
            end
            if (cnt == 7'(DIV_LATENCY - 2))
                done <= 1'b1;
            else
                cnt <= cnt + 7'd1;
        end
    end

endmodule

// File: rtl/div_fixup.sv
// Special-case detection and result selection for divide ops.
// Covers divide-by-zero, signed overflow and quot/rem sext select.
module div_fixup
    import div_ctrl_pkg::*;
(
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    input  div_op_t      op,
    input  logic         w,
    input  logic [127:0] c,
    output logic         special,
    output logic [63:0]  special_result,
    output logic [63:0]  result
);

    logic         s;
    logic         bz;
    logic         ovf;
    logic [127:0] sc;

    assign s  = is_signed(op);
    assign bz = w ? (b[31:0] == 32'h0) : (b == 64'h0);

    assign ovf = s & (w ? (a[31:0] == MIN32 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF));

    // Build the architectural {rem, quot} pair for the special cases.
    always_comb begin
        sc = '0;
        if (bz)
            sc = {a, 64'hFFFF_FFFF_FFFF_FFFF};
        else if (ovf)
            sc = {64'h0, w ? {32'h0, MIN32} : MIN64};
    end

    assign special        = bz | ovf;
    assign special_result = sel_result(sc, is_rem(op), w);
    assign result         = sel_result(c, is_rem(op), w);

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller around the iterative divider.
// Handles specials, quot/rem result reuse and tagged responses.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TAG_W    = 5,
    parameter int EN_REUSE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  div_op_t          req_op,
    input  logic             req_w,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    div_state_t       state;
    logic [63:0]      a_q;
    logic [63:0]      b_q;
    div_op_t          op_q;
    logic             w_q;
    logic [TAG_W-1:0] tag_q;

    logic             cv;
    logic [63:0]      ca;
    logic [63:0]      cb;
    logic             cs;
    logic             cw;
    logic [127:0]     cc;

    logic             div_valid;
    logic             div_done;
    logic [127:0]     div_c;

    logic             idle;
    logic             hit;
    logic [63:0]      fx_a;
    logic [63:0]      fx_b;
    div_op_t          fx_op;
    logic             fx_w;
    logic [127:0]     fx_c;
    logic             fx_special;
    logic [63:0]      fx_special_res;
    logic [63:0]      fx_res;

    assign idle = (state == IDLE);

    // In IDLE the fixup looks at the incoming request and the cache;
    // otherwise at the latched operands and the live divider result.
    assign fx_a  = idle ? req_a  : a_q;
    assign fx_b  = idle ? req_b  : b_q;
    assign fx_op = idle ? req_op : op_q;
    assign fx_w  = idle ? req_w  : w_q;
    assign fx_c  = idle ? cc     : div_c;

    assign hit = (EN_REUSE != 0) && cv
              && req_a == ca && req_b == cb
              && is_signed(req_op) == cs && req_w == cw;

    assign div_valid = (state == RUN) & ~div_done & ~flush & ~reset;
    assign req_ready = idle & ~flush;
    assign busy      = ~idle;

    div_fixup u_fixup (
        .a              (fx_a),
        .b              (fx_b),
        .op             (fx_op),
        .w              (fx_w),
        .c              (fx_c),
        .special        (fx_special),
        .special_result (fx_special_res),
        .result         (fx_res)
    );

    div u_div (
        .clk   (clk),
        .reset (reset),
        .valid (div_valid),
        .a     (a_q),
        .b     (b_q),
        .s     (is_signed(op_q)),
        .w     (w_q),
        .done  (div_done),
        .c     (div_c)
    );

    // Request/run/response sequencing, cache update and output regs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
            cv         <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= DIV;
            w_q        <= 1'b0;
            tag_q      <= '0;
        end else if (flush) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q   <= req_a;
                        b_q   <= req_b;
                        op_q  <= req_op;
                        w_q   <= req_w;
                        tag_q <= req_tag;
                        if (fx_special) begin
                            resp_data  <= fx_special_res;
                            resp_tag   <= req_tag;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (hit) begin
                            resp_data  <= fx_res;
                            resp_tag   <= req_tag;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (div_done) begin
                        cv         <= 1'b1;
                        ca         <= a_q;
                        cb         <= b_q;
                        cs         <= is_signed(op_q);
                        cw         <= w_q;
                        cc         <= div_c;
                        resp_data  <= fx_res;
                        resp_tag   <= tag_q;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases plus random ops
// compared against an arithmetic RISC-V divide model.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int FAST = 1;
    localparam int SLOW = 69;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    div_op_t     req_op;
    logic        req_w;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [4:0]  req_tag;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int dv_cnt  = 0;

    logic        m_cv;
    logic [63:0] m_ca;
    logic [63:0] m_cb;
    logic        m_cs;
    logic        m_cw;

    always #5 clk = ~clk;

    div_ctrl #(.TAG_W(5), .EN_REUSE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_w      (req_w),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    always @(posedge clk) if (dut.div_valid) dv_cnt <= dv_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic sgn(input div_op_t op);
        return op == DIV || op == REM;
    endfunction

    function automatic logic [63:0] ref_res(input div_op_t op, input logic w,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32, v32;
        logic [63:0] q, r;
        int          x, y;
        longint      sx, sy;
        a32 = a[31:0];
        b32 = b[31:0];
        x   = a32;
        y   = b32;
        sx  = a;
        sy  = b;
        if (w) begin
            if (b32 == 0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (sgn(op)) begin
                if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                    q32 = a32; r32 = 0;
                end else begin
                    q32 = 32'(x / y); r32 = 32'(x % y);
                end
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            v32 = (op == REM || op == REMU) ? r32 : q32;
            return {{32{v32[31]}}, v32};
        end
        if (b == 0) begin
            q = '1; r = a;
        end else if (sgn(op)) begin
            if (a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 0;
            end else begin
                q = 64'(sx / sy); r = 64'(sx % sy);
            end
        end else begin
            q = a / b; r = a % b;
        end
        return (op == REM || op == REMU) ? r : q;
    endfunction

    function automatic logic ref_special(input div_op_t op, input logic w,
                                         input logic [63:0] a,
                                         input logic [63:0] b);
        if (w)
            return b[31:0] == 0 ||
                   (sgn(op) && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
        return b == 0 || (sgn(op) && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    task automatic start_op(input div_op_t op, input logic w,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] tag);
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_w     = w;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("req_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_op(input div_op_t op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] tag, input int hold);
        logic [63:0] exp;
        logic        sp, hit;
        int          lat, dv0;
        exp = ref_res(op, w, a, b);
        sp  = ref_special(op, w, a, b);
        hit = !sp && m_cv && a == m_ca && b == m_cb
              && sgn(op) == m_cs && w == m_cw;
        dv0 = dv_cnt;
        start_op(op, w, a, b, tag);
        lat = 1;
        while (!resp_valid && lat < 300) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", 64'(lat), 64'((sp || hit) ? FAST : SLOW));
        chk("data", resp_data, exp);
        chk("tag", 64'(resp_tag), 64'(tag));
        chk("div_cycles", 64'(dv_cnt - dv0), 64'((sp || hit) ? 0 : 67));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_data", resp_data, exp);
            chk("hold_tag", 64'(resp_tag), 64'(tag));
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("resp_clear", 64'(resp_valid), 64'd0);
        if (!sp && !hit) begin
            m_cv = 1'b1; m_ca = a; m_cb = b; m_cs = sgn(op); m_cw = w;
        end
    endtask

    function automatic logic [63:0] pick();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 6))
            0: v = 64'($urandom_range(0, 50));
            1: v = 64'h0;
            2: v = '1;
            3: v = 64'h8000_0000_0000_0000;
            4: v = {v[63:32], 32'h8000_0000};
            5: v = {v[63:32], 32'hFFFF_FFFF};
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        logic        seen;
        div_op_t     op;
        logic        w;
        logic [63:0] a, b;
        reset = 1'b1; req_valid = 1'b0; req_op = DIV; req_w = 1'b0;
        req_a = '0; req_b = '0; req_tag = '0; flush = 1'b0;
        resp_ready = 1'b0;
        m_cv = 1'b0; m_ca = '0; m_cb = '0; m_cs = 1'b0; m_cw = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_data", resp_data, 64'd0);
        chk("rst_tag", 64'(resp_tag), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        run_op(DIVU, 1'b0, 64'd100, 64'd7, 5'd1, 0);
        run_op(REMU, 1'b0, 64'd100, 64'd7, 5'd2, 0);
        run_op(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 0);
        run_op(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 0);
        run_op(DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd5, 0);
        run_op(REM, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd6, 0);
        run_op(REMU, 1'b0, 64'h1234, 64'd0, 5'd7, 0);
        run_op(DIV, 1'b0, 64'h1234, 64'd0, 5'd8, 0);

        start_op(DIVU, 1'b0, 64'd1000, 64'd3, 5'd9);
        repeat (29) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_dv", 64'(dut.div_valid), 64'd0);
        chk("flush_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1 if (resp_valid) seen = 1'b1;
        end
        chk("flush_no_resp", 64'(seen), 64'd0);
        run_op(DIVU, 1'b0, 64'd9, 64'd2, 5'd10, 10);

        start_op(DIVU, 1'b1, 64'd12345, 64'd17, 5'd11);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_cv = 1'b0;
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_data", resp_data, 64'd0);
        chk("mid_rst_tag", 64'(resp_tag), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        run_op(DIVU, 1'b0, 64'd9, 64'd2, 5'd12, 0);
        run_op(REMU, 1'b0, 64'd9, 64'd2, 5'd13, 0);

        a = 64'd1; b = 64'd1; op = DIVU; w = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                op = div_op_t'(op ^ 2'b10);
            end else begin
                a  = pick();
                b  = pick();
                w  = 1'($urandom_range(0, 1));
                op = div_op_t'($urandom_range(0, 3));
            end
            run_op(op, w, a, b, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller for the iterative 64-bit divider `div` (valid/done, 128-bit {rem, quot} result). Instantiates one `div` internally.
- Accepts DIV/DIVU/REM/REMU and their W forms from the execute stage over a valid/ready handshake.
- Resolves RISC-V divide-by-zero and signed-overflow cases without starting the divider.
- Reuses the previous divider result for a complementary DIV/REM pair, then returns a tagged, XLEN-wide, correctly sign-extended result.

Parameters:
TAG_W, 5, width of the destination tag carried with each request.
EN_REUSE, 1, when 1, a result cache serves the complementary quotient/remainder op in 1 cycle.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when valid&ready.
req_op  in  2  div_op_t: DIV=0, DIVU=1, REM=2, REMU=3.
req_w  in  1  1 = 32-bit W form.
req_a  in  64  dividend (rs1).
req_b  in  64  divisor (rs2).
req_tag  in  TAG_W  destination tag.
flush  in  1  abort any in-flight op.
resp_valid  out  1  result present.
resp_ready  in  1  consumer accepts.
resp_data  out  64  result.
resp_tag  out  TAG_W  tag of the request.
busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, RUN, RESP. Reset puts the block in IDLE with req_ready=1, resp_valid=0, resp_data=0, resp_tag=0, busy=0, cache invalid, internal div_valid=0.
- Operand latch: on acceptance, a, b, op, w, and tag are registered. They drive the divider's a/b/s/w, with s = (op==DIV or REM). They stay stable until leaving RUN, because the divider's result is combinational on them.
- Special cases, decided at acceptance, go IDLE->RESP with the response 1 cycle later:
  - Divide by zero (b==0, or b[31:0]==0 when w): quotient = all ones; remainder = a (when w: sext(a[31:0])).
  - Signed overflow (s, a==MIN, b==-1, checked on 32-bit values when w): quotient = MIN (when w: 0xFFFFFFFF80000000); remainder = 0.
- Reuse (EN_REUSE): the cache holds {a, b, s, w, 128-bit c} of the last completed divider run. If a request has the identical a, b, s, w as the cache, it goes IDLE->RESP with the result selected from the cache.
- Otherwise the block enters RUN:
  - div_valid = (state==RUN) & ~div_done, combinational. It must fall in the cycle done is seen; otherwise the divider restarts.
  - div_done is ignored outside RUN.
- RUN->RESP on the first cycle div_done=1. On that edge, c is captured into the cache and the result register.
- Latency: resp_valid rises 68 edges after the accepting edge (divider 67 + capture 1).
- Result select: quotient = c[63:0], remainder = c[127:64]. When w, resp_data = sext(selected[31:0]) in every path.
- RESP holds resp_data and resp_tag stable until resp_ready, then goes RESP->IDLE.
- At least one IDLE cycle (div_valid low) always separates divider runs, so the divider returns to its idle state and its done flag clears.
- req_ready = (state==IDLE) & ~flush. There is no acceptance in the same cycle as a response handshake.
- Flush:
  - In any state, flush moves to IDLE next edge and clears resp_valid.
  - div_valid is 0 in the flush cycle, which aborts the divider.
  - The cache is untouched; an aborted run never writes it.
  - Flush wins over a simultaneous req_valid or resp_ready.
- Reset mid-RUN: same as flush, plus the cache is invalidated.

Decomposition:
- Package div_ctrl_pkg holds:
  - div_op_t enum;
  - div_state_t {IDLE, RUN, RESP};
  - DIV_LATENCY=67;
  - MIN64/MIN32 constants;
  - helpers is_signed(op) and is_rem(op).
- Sub-module div_fixup (combinational) takes a, b, op, and w. It outputs special (1), special_result (64), and the sext/select function for c. It is used for both special cases and normal results.

Test Plan:
- DIVU a=100, b=7, w=0 -> resp_data=14 with resp_valid 68 edges after accept; then REMU with the same operands -> 2, one cycle after accept, and no divider activity.
- DIV w=0, a=-7 (0xFFFFFFFFFFFFFFF9), b=2 -> 0xFFFFFFFFFFFFFFFD; REM with the same operands -> 0xFFFFFFFFFFFFFFFF.
- DIVW a=0x80000000, b=0xFFFFFFFF -> 0xFFFFFFFF80000000 after 1 cycle; REMW with the same operands -> 0.
- REMU b=0, a=0x1234 -> 0x1234; DIV b=0 -> 0xFFFFFFFFFFFFFFFF; both at 1-cycle latency.
- Start DIVU 1000/3, flush at cycle 30 -> resp_valid never rises and div_valid drops; new DIVU 9/2 -> 4 at full latency.
- Hold resp_ready=0 for 10 cycles -> resp_data/tag stable and req_ready=0; reset during RUN -> all outputs at reset values next edge.
